// File: rtl/pll_phase_seq.sv
// pll_phase_seq: power-up reset, lock filtering, output-clock gating and
// dynamic phase-shift sequencing for the CrossLink PLL primitive.
// Runs on the PLL reference clock so it keeps working while the PLL is unlocked.
module pll_phase_seq #(
  parameter int NUM_OUT    = 4,
  parameter int RST_CYCLES = 16,
  parameter int LOCK_FILT  = 256,
  parameter int STEP_HI    = 2,
  parameter int STEP_GAP   = 4,
  parameter int CNT_W      = 8
) (
  input  logic               CLKI,
  input  logic               RST,
  input  logic               pll_lock_i,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_sel,
  input  logic               req_dir,
  input  logic [CNT_W-1:0]   req_count,
  output logic               pll_rst_o,
  output logic [1:0]         phasesel_o,
  output logic               phasedir_o,
  output logic               phasestep_o,
  output logic               phaseloadreg_o,
  output logic [NUM_OUT-1:0] enclk_o,
  output logic               locked_o,
  output logic               done_o,
  output logic               req_err_o,
  output logic               lost_o,
  output logic [7:0]         relock_cnt_o
);

  // One shared timer covers the reset pulse, lock filter and step timing,
  // so it is sized for the longest of them (it counts 0..N-1).
  localparam int MAX_A = (RST_CYCLES > LOCK_FILT) ? RST_CYCLES : LOCK_FILT;
  localparam int MAX_B = (STEP_HI > STEP_GAP) ? STEP_HI : STEP_GAP;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW    = $clog2(MAX_T);

  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] FILT_LAST = TW'(LOCK_FILT - 1);
  localparam logic [TW-1:0] HI_LAST   = TW'(STEP_HI - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'(STEP_GAP - 1);

  typedef enum logic [2:0] {
    S_RST_SEQ,
    S_WAIT_LOCK,
    S_READY,
    S_SETUP,
    S_STEP_HI,
    S_STEP_GAP,
    S_LOAD,
    S_DONE
  } state_t;

  state_t           state_q, state_n;
  logic [TW-1:0]    tmr_q, tmr_n;
  logic [CNT_W-1:0] rem_q, rem_n;
  logic [1:0]       sel_q, sel_n;
  logic             dir_q, dir_n;
  logic             lock_m, lock_s;
  logic             done_n, err_n, lost_n;
  logic [7:0]       relock_n;
  logic             in_op, sel_ok, op_n, drive_n;

  // Two-flop synchroniser for the asynchronous PLL LOCK output.
  always_ff @(posedge CLKI or posedge RST) begin
    if (RST) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock_i;
      lock_s <= lock_m;
    end
  end

  // Next-state logic; losing lock while operating overrides everything else.
  always_comb begin
    state_n  = state_q;
    tmr_n    = tmr_q;
    rem_n    = rem_q;
    sel_n    = sel_q;
    dir_n    = dir_q;
    done_n   = 1'b0;
    err_n    = 1'b0;
    lost_n   = lost_o;
    relock_n = relock_cnt_o;
    in_op    = (state_q != S_RST_SEQ) && (state_q != S_WAIT_LOCK);
    sel_ok   = (int'(req_sel) < NUM_OUT);

    if (in_op && !lock_s) begin
      state_n = S_RST_SEQ;
      tmr_n   = '0;
      lost_n  = 1'b1;
      if (relock_cnt_o != 8'hFF) relock_n = relock_cnt_o + 8'd1;
    end else begin
      case (state_q)
        S_RST_SEQ: begin
          if (tmr_q == RST_LAST) begin
            state_n = S_WAIT_LOCK;
            tmr_n   = '0;
          end else begin
            tmr_n = tmr_q + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (!lock_s) begin
            tmr_n = '0;
          end else if (tmr_q == FILT_LAST) begin
            state_n = S_READY;
            tmr_n   = '0;
          end else begin
            tmr_n = tmr_q + 1'b1;
          end
        end
        S_READY: begin
          if (req_valid) begin
            if (!sel_ok) begin
              err_n = 1'b1;
            end else if (req_count == '0) begin
              done_n = 1'b1;
            end else begin
              state_n = S_SETUP;
              tmr_n   = '0;
              rem_n   = req_count;
              sel_n   = req_sel;
              dir_n   = req_dir;
            end
          end
        end
        S_SETUP: begin
          if (tmr_q == GAP_LAST) begin
            state_n = S_STEP_HI;
            tmr_n   = '0;
          end else begin
            tmr_n = tmr_q + 1'b1;
          end
        end
        S_STEP_HI: begin
          if (tmr_q == HI_LAST) begin
            state_n = S_STEP_GAP;
            tmr_n   = '0;
          end else begin
            tmr_n = tmr_q + 1'b1;
          end
        end
        S_STEP_GAP: begin
          if (tmr_q == GAP_LAST) begin
            tmr_n   = '0;
            rem_n   = rem_q - 1'b1;
            state_n = (rem_q == CNT_W'(1)) ? S_LOAD : S_STEP_HI;
          end else begin
            tmr_n = tmr_q + 1'b1;
          end
        end
        S_LOAD: begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end
        S_DONE: begin
          state_n = S_READY;
          sel_n   = 2'd0;
          dir_n   = 1'b0;
        end
        default: begin
          state_n = S_RST_SEQ;
          tmr_n   = '0;
        end
      endcase
    end

    op_n    = (state_n != S_RST_SEQ) && (state_n != S_WAIT_LOCK);
    drive_n = (state_n == S_SETUP) || (state_n == S_STEP_HI) ||
              (state_n == S_STEP_GAP) || (state_n == S_LOAD);
  end

  // Sequencer state, timer and latched request.
  always_ff @(posedge CLKI or posedge RST) begin
    if (RST) begin
      state_q <= S_RST_SEQ;
      tmr_q   <= '0;
      rem_q   <= '0;
      sel_q   <= 2'd0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      tmr_q   <= tmr_n;
      rem_q   <= rem_n;
      sel_q   <= sel_n;
      dir_q   <= dir_n;
    end
  end

  // All PLL pins and status flags are registered so they never glitch.
  always_ff @(posedge CLKI or posedge RST) begin
    if (RST) begin
      pll_rst_o      <= 1'b1;
      locked_o       <= 1'b0;
      enclk_o        <= '0;
      req_ready      <= 1'b0;
      phasesel_o     <= 2'd0;
      phasedir_o     <= 1'b0;
      phasestep_o    <= 1'b0;
      phaseloadreg_o <= 1'b0;
      done_o         <= 1'b0;
      req_err_o      <= 1'b0;
      lost_o         <= 1'b0;
      relock_cnt_o   <= 8'd0;
    end else begin
      pll_rst_o      <= (state_n == S_RST_SEQ);
      locked_o       <= op_n;
      enclk_o        <= {NUM_OUT{op_n}};
      req_ready      <= (state_n == S_READY);
      phasesel_o     <= drive_n ? sel_n : 2'd0;
      phasedir_o     <= drive_n ? dir_n : 1'b0;
      phasestep_o    <= (state_n == S_STEP_HI);
      phaseloadreg_o <= (state_n == S_LOAD);
      done_o         <= done_n;
      req_err_o      <= err_n;
      lost_o         <= lost_n;
      relock_cnt_o   <= relock_n;
    end
  end

endmodule

// File: tb/tb_pll_phase_seq.sv
// tb_pll_phase_seq: scoreboard bench for pll_phase_seq with directed lock
// scenarios and randomized phase-shift requests.
module tb_pll_phase_seq;

  localparam int NUM_OUT    = 3;
  localparam int RST_CYCLES = 16;
  localparam int LOCK_FILT  = 8;
  localparam int STEP_HI    = 2;
  localparam int STEP_GAP   = 4;
  localparam int CNT_W      = 8;

  localparam int K_DONE  = 0;
  localparam int K_ERR   = 1;
  localparam int K_ABORT = 2;

  logic               CLKI = 1'b0;
  logic               RST = 1'b1;
  logic               pll_lock_i = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [1:0]         req_sel = 2'd0;
  logic               req_dir = 1'b0;
  logic [CNT_W-1:0]   req_count = '0;
  logic               pll_rst_o;
  logic [1:0]         phasesel_o;
  logic               phasedir_o;
  logic               phasestep_o;
  logic               phaseloadreg_o;
  logic [NUM_OUT-1:0] enclk_o;
  logic               locked_o;
  logic               done_o;
  logic               req_err_o;
  logic               lost_o;
  logic [7:0]         relock_cnt_o;

  typedef struct {
    int kind;
    int sel;
    int dir;
    int steps;
    int hi_cycles;
    int loads;
    int lat;
    int hs;
  } expect_t;

  expect_t sb[$];
  int assert_count = 0;
  int fail_count   = 0;
  int cyc          = 0;

  int m_rises, m_hi, m_loads, m_sel, m_dir, m_sel_bad;
  bit m_prev_step, m_prev_locked;

  pll_phase_seq #(
    .NUM_OUT(NUM_OUT), .RST_CYCLES(RST_CYCLES), .LOCK_FILT(LOCK_FILT),
    .STEP_HI(STEP_HI), .STEP_GAP(STEP_GAP), .CNT_W(CNT_W)
  ) dut (
    .CLKI(CLKI), .RST(RST), .pll_lock_i(pll_lock_i),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .req_dir(req_dir), .req_count(req_count), .pll_rst_o(pll_rst_o),
    .phasesel_o(phasesel_o), .phasedir_o(phasedir_o), .phasestep_o(phasestep_o),
    .phaseloadreg_o(phaseloadreg_o), .enclk_o(enclk_o), .locked_o(locked_o),
    .done_o(done_o), .req_err_o(req_err_o), .lost_o(lost_o),
    .relock_cnt_o(relock_cnt_o)
  );

  always #5 CLKI = ~CLKI;

  always @(posedge CLKI) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assert_count++;
    if (actual != expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: outcome of one request from the behavioural rules.
  function automatic expect_t modelRequest(input int sel, input int dir, input int count,
                                           input bit abort_planned, input int hs);
    expect_t e;
    e.sel = sel;
    e.dir = dir;
    e.hs  = hs;
    if (abort_planned)     e.kind = K_ABORT;
    else if (sel >= NUM_OUT) e.kind = K_ERR;
    else                   e.kind = K_DONE;
    if (sel >= NUM_OUT || count == 0) begin
      e.steps = 0; e.hi_cycles = 0; e.loads = 0; e.lat = 0;
    end else begin
      e.steps     = count;
      e.hi_cycles = count * STEP_HI;
      e.loads     = 1;
      e.lat       = STEP_GAP + count * (STEP_HI + STEP_GAP) + 1;
    end
    return e;
  endfunction

  // Called at a negedge; returns at the negedge just after the handshake edge.
  task automatic applyStimulus(input int sel, input int dir, input int count, input bit abort_planned);
    int guard = 0;
    while (!req_ready && guard < 500) begin
      @(negedge CLKI);
      guard++;
    end
    if (!req_ready) begin
      checkOutput("req_ready_timeout", 0, 1);
      return;
    end
    sb.push_back(modelRequest(sel, dir, count, abort_planned, cyc + 1));
    req_valid = 1'b1;
    req_sel   = 2'(sel);
    req_dir   = dir[0];
    req_count = CNT_W'(count);
    @(posedge CLKI);
    @(negedge CLKI);
    req_valid = 1'b0;
  endtask

  // Monitor: tracks pin activity and retires scoreboard entries on responses.
  always @(negedge CLKI) begin
    expect_t e;
    if (RST) begin
      m_rises = 0; m_hi = 0; m_loads = 0; m_sel = 0; m_dir = 0; m_sel_bad = 0;
      m_prev_step = 1'b0; m_prev_locked = 1'b0;
    end else begin
      if (phasestep_o) begin
        m_hi++;
        if (!m_prev_step) begin
          m_rises++;
          if (m_rises == 1) begin
            m_sel = int'(phasesel_o);
            m_dir = int'(phasedir_o);
          end
        end
      end
      if (phaseloadreg_o) m_loads++;
      if ((phasestep_o || phaseloadreg_o) && m_rises > 0 &&
          (int'(phasesel_o) != m_sel || int'(phasedir_o) != m_dir))
        m_sel_bad++;

      if (done_o || req_err_o) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_response", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("resp_kind", done_o ? K_DONE : K_ERR, e.kind);
          checkOutput("resp_latency", cyc - e.hs, e.lat);
          checkOutput("step_pulses", m_rises, e.steps);
          checkOutput("step_hi_cycles", m_hi, e.hi_cycles);
          checkOutput("load_pulses", m_loads, e.loads);
          if (e.steps > 0) begin
            checkOutput("phasesel", m_sel, e.sel);
            checkOutput("phasedir", m_dir, e.dir);
            checkOutput("sel_dir_stable", m_sel_bad, 0);
          end
        end
        m_rises = 0; m_hi = 0; m_loads = 0; m_sel_bad = 0;
      end

      if (m_prev_locked && !locked_o) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("abort_kind", K_ABORT, e.kind);
        end
        m_rises = 0; m_hi = 0; m_loads = 0; m_sel_bad = 0;
      end
      m_prev_step   = phasestep_o;
      m_prev_locked = locked_o;
    end
  end

  // Main stimulus sequence.
  initial begin
    int n, g, rises, rdy_high, sel, dir, count;
    bit prev;

    repeat (3) @(negedge CLKI);
    $display("[TB] reset state");
    checkOutput("rst_pll_rst", int'(pll_rst_o), 1);
    checkOutput("rst_enclk", int'(enclk_o), 0);
    checkOutput("rst_locked_ready", int'({locked_o, req_ready}), 0);
    checkOutput("rst_phase_pins", int'({phasesel_o, phasedir_o, phasestep_o, phaseloadreg_o}), 0);
    checkOutput("rst_flags", int'({done_o, req_err_o, lost_o}), 0);
    checkOutput("rst_relock_cnt", int'(relock_cnt_o), 0);

    // Power-up reset pulse length
    RST = 1'b0;
    n = 0;
    while (pll_rst_o && n < 200) begin
      n++;
      @(negedge CLKI);
    end
    checkOutput("powerup_pll_rst_cycles", n, RST_CYCLES);

    // Lock arrives at cycle 30; locked after sync plus full filter
    repeat (30 - RST_CYCLES) @(negedge CLKI);
    pll_lock_i = 1'b1;
    n = 0;
    while (!locked_o && n < 200) begin
      @(negedge CLKI);
      n++;
    end
    checkOutput("powerup_lock_latency", n, 2 + LOCK_FILT);
    checkOutput("enclk_on", int'(enclk_o), (1 << NUM_OUT) - 1);
    checkOutput("ready_after_lock", int'(req_ready), 1);

    // Directed request sel=1 dir=1 count=3; ready stays low while busy
    $display("[TB] directed requests");
    applyStimulus(1, 1, 3, 1'b0);
    rdy_high = 0;
    g = 0;
    while (!done_o && g < 100) begin
      if (req_ready) rdy_high++;
      @(negedge CLKI);
      g++;
    end
    checkOutput("busy_ready_low", rdy_high, 0);
    @(negedge CLKI);
    applyStimulus(0, 0, 0, 1'b0);
    applyStimulus(3, 0, 2, 1'b0);

    // Randomized requests
    $display("[TB] random requests");
    for (int i = 0; i < 30; i++) begin
      sel   = $urandom_range(0, 3);
      dir   = $urandom_range(0, 1);
      count = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 5);
      applyStimulus(sel, dir, count, 1'b0);
    end
    g = 0;
    while (sb.size() > 0 && g < 2000) begin
      @(negedge CLKI);
      g++;
    end
    checkOutput("scoreboard_drain_random", sb.size(), 0);

    // Lock loss during the second step
    $display("[TB] lock loss");
    applyStimulus(2, 0, 4, 1'b1);
    rises = 0;
    prev  = 1'b0;
    g = 0;
    while (rises < 2 && g < 300) begin
      @(negedge CLKI);
      if (phasestep_o && !prev) rises++;
      prev = phasestep_o;
      g++;
    end
    checkOutput("second_step_seen", rises, 2);
    pll_lock_i = 1'b0;
    n = 0;
    while (locked_o && n < 20) begin
      @(negedge CLKI);
      n++;
    end
    checkOutput("lock_loss_latency", n, 3);
    checkOutput("loss_enclk", int'(enclk_o), 0);
    checkOutput("loss_lost", int'(lost_o), 1);
    checkOutput("loss_relock_cnt", int'(relock_cnt_o), 1);
    checkOutput("loss_phase_pins", int'({phasesel_o, phasedir_o, phasestep_o, phaseloadreg_o}), 0);
    checkOutput("loss_ready_done", int'({req_ready, done_o}), 0);
    n = 0;
    while (pll_rst_o && n < 200) begin
      n++;
      @(negedge CLKI);
    end
    checkOutput("relock_pll_rst_cycles", n, RST_CYCLES);

    // Relock with a one-cycle glitch at filter count 5
    repeat (3) @(negedge CLKI);
    pll_lock_i = 1'b1;
    repeat (5) @(negedge CLKI);
    pll_lock_i = 1'b0;
    @(negedge CLKI);
    pll_lock_i = 1'b1;
    n = 0;
    while (!locked_o && n < 200) begin
      @(negedge CLKI);
      n++;
    end
    checkOutput("glitch_lock_latency", n, 2 + LOCK_FILT);
    checkOutput("relock_lost_sticky", int'(lost_o), 1);
    checkOutput("relock_cnt_held", int'(relock_cnt_o), 1);
    checkOutput("relock_enclk", int'(enclk_o), (1 << NUM_OUT) - 1);

    for (int i = 0; i < 4; i++) begin
      sel   = $urandom_range(0, 3);
      dir   = $urandom_range(0, 1);
      count = $urandom_range(0, 4);
      applyStimulus(sel, dir, count, 1'b0);
    end
    g = 0;
    while (sb.size() > 0 && g < 1000) begin
      @(negedge CLKI);
      g++;
    end
    checkOutput("scoreboard_drain_relock", sb.size(), 0);

    // Asynchronous reset in the middle of a step pulse
    $display("[TB] reset during step");
    applyStimulus(0, 1, 5, 1'b0);
    g = 0;
    while (!phasestep_o && g < 100) begin
      @(negedge CLKI);
      g++;
    end
    checkOutput("step_before_reset", int'(phasestep_o), 1);
    RST = 1'b1;
    #1;
    checkOutput("midrst_phasestep", int'(phasestep_o), 0);
    checkOutput("midrst_pll_rst", int'(pll_rst_o), 1);
    checkOutput("midrst_lost", int'(lost_o), 0);
    checkOutput("midrst_relock_cnt", int'(relock_cnt_o), 0);
    checkOutput("midrst_enclk", int'(enclk_o), 0);
    sb.delete();
    repeat (2) @(negedge CLKI);
    RST = 1'b0;
    @(negedge CLKI);
    checkOutput("post_rst_pll_rst", int'(pll_rst_o), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
